cella_ctrl: RTL and testbench

Command sequencer placed directly upstream of the CELLA row decoder. It accepts one host command at a time: a write, a CAM search, or a MAC read in either polarity. For each command it drives the decoder's chip-select, mode, address and data lines with a fixed setup/active/precharge sequence. Access completion is self-timed from the replica (dummy) column. The block captures the sense-amp/match-line result and returns it with an error flag.

---
 rtl/cella_pkg.sv | 8 +
 rtl/cella_timer.sv | 19 +
 rtl/cella_ctrl.sv | 130 +++++++++++++
 tb/tb_cella_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cella_pkg.sv
// cella_pkg: op encodings and sequencer state shared by the CELLA controller and row decoder
package cella_pkg;
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_MAC    = 2'b10;
  localparam logic [1:0] OP_MACB   = 2'b11;
  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, RECOV, RESP} state_e;
endpackage

// File: rtl/cella_timer.sv
// cella_timer: loadable down-counter with terminal flag at zero
module cella_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // load wins; otherwise count down and park at zero
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == '0;
endmodule

// File: rtl/cella_ctrl.sv
// cella_ctrl: one-command-at-a-time sequencer driving the CELLA row decoder
module cella_ctrl
  import cella_pkg::*;
#(
  parameter int WRITE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int PRECH_CYCLES   = 1,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_addr,
  input  logic [3:0] cmd_data,
  output logic       cs,
  output logic       MAC_en,
  output logic       read_bar,
  output logic       w_en,
  output logic [1:0] addr,
  output logic [3:0] data,
  output logic       pre,
  input  logic       dummy_done,
  input  logic [3:0] sense,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_err
);
  localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PR_LD = CNT_W'(PRECH_CYCLES - 1);

  state_e           state_q;
  logic [1:0]       op_q, addr_q;
  logic [3:0]       data_q, cap_q, rsp_data_q;
  logic             err_q, rsp_err_q, rsp_valid_q, cmd_ready_q;
  logic             cs_q, pre_q, w_en_q, mac_en_q, read_bar_q;
  logic [CNT_W-1:0] tmr_cnt, tmr_val;
  logic             tmr_tc, tmr_load, is_wr, hit, leave_act;

  assign is_wr = op_q == OP_WRITE;
  // the timer still holds its load value on the first ACTIVE cycle, before wordlines have risen
  assign hit       = !is_wr && dummy_done && tmr_cnt != TO_LD;
  assign leave_act = state_q == ACTIVE && (hit || tmr_tc);
  assign tmr_load  = state_q == SETUP || leave_act;
  assign tmr_val   = state_q == SETUP ? (is_wr ? WR_LD : TO_LD) : PR_LD;

  cella_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load_i(tmr_load),
    .val_i (tmr_val),
    .cnt_o (tmr_cnt),
    .tc_o  (tmr_tc)
  );

  // sequencer FSM; every decoder and response output is a register set on the transition into its state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      err_q       <= 1'b0;
      cs_q        <= 1'b0;
      pre_q       <= 1'b1;
      w_en_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      read_bar_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          state_q     <= SETUP;
          op_q        <= cmd_op;
          addr_q      <= cmd_addr;
          data_q      <= cmd_data;
          cmd_ready_q <= 1'b0;
          pre_q       <= 1'b0;
          w_en_q      <= cmd_op == OP_WRITE;
          mac_en_q    <= cmd_op[1];
          read_bar_q  <= cmd_op[1] & cmd_op[0];
        end
        SETUP: begin
          state_q <= ACTIVE;
          cs_q    <= 1'b1;
        end
        ACTIVE: if (leave_act) begin
          state_q <= RECOV;
          cs_q    <= 1'b0;
          pre_q   <= 1'b1;
          cap_q   <= hit ? sense : 4'h0;
          err_q   <= !hit && !is_wr;
        end
        RECOV: if (tmr_tc) begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= cap_q;
          rsp_err_q   <= err_q;
          w_en_q      <= 1'b0;
          mac_en_q    <= 1'b0;
          read_bar_q  <= 1'b0;
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cs        = cs_q;
  assign pre       = pre_q;
  assign w_en      = w_en_q;
  assign MAC_en    = mac_en_q;
  assign read_bar  = read_bar_q;
  assign addr      = addr_q;
  assign data      = data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_cella_ctrl.sv
// tb_cella_ctrl: directed table-driven checks of the CELLA command sequencer
module tb_cella_ctrl;
  logic       clk = 0, rst = 1, cmd_valid = 0, dummy_done = 0;
  logic [1:0] cmd_op = 0, cmd_addr = 0;
  logic [3:0] cmd_data = 0, sense = 0;
  logic       cmd_ready, cs, MAC_en, read_bar, w_en, pre, rsp_valid, rsp_err;
  logic [1:0] addr;
  logic [3:0] data, rsp_data;
  int checks = 0, errors = 0;

  cella_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cs(cs), .MAC_en(MAC_en), .read_bar(read_bar), .w_en(w_en),
    .addr(addr), .data(data), .pre(pre), .dummy_done(dummy_done),
    .sense(sense), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op, ad;
    logic [3:0] dat;
    int         k0, k1;
    logic [3:0] sen;
    int         lat;
    logic [3:0] rd;
    logic       er;
    int         csn;
    logic       w, m, rb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input int idx);
    int n, lat, csn, bad;
    logic [3:0] rd;
    logic er;
    lat = 0; csn = 0; bad = 0; rd = 0; er = 0;
    chk($sformatf("v%0d_ready", idx), cmd_ready, 1);
    cmd_valid = 1; cmd_op = v.op; cmd_addr = v.ad; cmd_data = v.dat; sense = v.sen;
    step();
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0;
    n = 1;
    while (n <= 30 && lat == 0) begin
      if (n == 1) begin
        chk($sformatf("v%0d_setup_cs", idx), cs, 0);
        chk($sformatf("v%0d_setup_pre", idx), pre, 0);
        chk($sformatf("v%0d_setup_mode", idx), {w_en, MAC_en, read_bar}, {v.w, v.m, v.rb});
        chk($sformatf("v%0d_setup_ad", idx), {addr, data}, {v.ad, v.dat});
      end
      if (cs && pre) bad++;
      if (cmd_ready) bad++;
      if (cs) begin
        csn++;
        if ({w_en, MAC_en, read_bar, addr, data} !== {v.w, v.m, v.rb, v.ad, v.dat}) bad++;
      end
      if (rsp_valid) begin
        lat = n; rd = rsp_data; er = rsp_err;
      end
      dummy_done = (n == 2 + v.k0) || (n == 2 + v.k1);
      if (lat == 0) begin
        step();
        n++;
      end
    end
    dummy_done = 0;
    chk($sformatf("v%0d_lat", idx), lat, v.lat);
    chk($sformatf("v%0d_rsp_data", idx), rd, v.rd);
    chk($sformatf("v%0d_rsp_err", idx), er, v.er);
    chk($sformatf("v%0d_cs_cycles", idx), csn, v.csn);
    chk($sformatf("v%0d_hold", idx), bad, 0);
    step();
    chk($sformatf("v%0d_idle", idx), {cmd_ready, rsp_valid, cs, pre, w_en, MAC_en}, 6'b100100);
    chk($sformatf("v%0d_keep_rsp", idx), {rsp_data, rsp_err}, {v.rd, v.er});
  endtask

  initial begin
    int nr, bad, rc;
    vecs[0] = '{2'd0, 2'd2, 4'hA, 99, 99, 4'h0,  5, 4'h0, 1'b0,  2, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 2'd0, 4'h5,  3, 99, 4'h4,  7, 4'h4, 1'b0,  4, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'd3, 2'd1, 4'hC,  0,  1, 4'h6,  5, 4'h6, 1'b0,  2, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{2'd1, 2'd3, 4'h5, 99, 99, 4'h9, 18, 4'h0, 1'b1, 15, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'd2, 2'd2, 4'h3, 14, 99, 4'hF, 18, 4'hF, 1'b0, 15, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'd0, 2'd1, 4'h7,  0,  2, 4'h7,  5, 4'h0, 1'b0,  2, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{2'd1, 2'd2, 4'h1,  0, 99, 4'h3, 18, 4'h0, 1'b1, 15, 1'b0, 1'b0, 1'b0};
    repeat (3) step();
    rst = 0;
    step();
    chk("reset_ctrl", {cmd_ready, cs, pre, rsp_valid, rsp_err}, 5'b10100);
    chk("reset_mode", {w_en, MAC_en, read_bar, addr, data, rsp_data}, 0);
    for (int i = 0; i < 7; i++) run(vecs[i], i);
    // accept and reset in the same cycle: reset wins
    cmd_valid = 1; cmd_op = 2'd0; rst = 1;
    step();
    cmd_valid = 0; rst = 0;
    chk("acc_rst_ready", cmd_ready, 1);
    bad = 0;
    repeat (8) begin step(); if (rsp_valid || cs || !cmd_ready) bad++; end
    chk("acc_rst_dropped", bad, 0);
    // reset in the middle of ACTIVE
    cmd_valid = 1; cmd_op = 2'd1; cmd_data = 4'h5;
    step();
    cmd_valid = 0;
    step(); step();
    chk("mid_active_cs", cs, 1);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_lines", {cs, pre, cmd_ready, rsp_valid, w_en, MAC_en}, 6'b011000);
    bad = 0;
    repeat (20) begin step(); if (rsp_valid) bad++; end
    chk("mid_rst_no_rsp", bad, 0);
    run(vecs[0], 7);
    // back-to-back writes with cmd_valid held high
    cmd_valid = 1; cmd_op = 2'd0; cmd_addr = 2'd3; cmd_data = 4'h6;
    bad = 0; nr = 0; rc = 0;
    for (int i = 0; i < 18; i++) begin
      if (cmd_ready !== (i % 6 == 0)) bad++;
      if (rsp_valid !== (i % 6 == 5)) bad++;
      if (cs && pre) bad++;
      nr += cmd_ready; rc += rsp_valid;
      step();
    end
    cmd_valid = 0;
    chk("b2b_pattern", bad, 0);
    chk("b2b_accepts", nr, 3);
    chk("b2b_rsps", rc, 3);
    repeat (20) step();
    chk("final_idle", {cmd_ready, cs, pre}, 3'b101);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
